// File: rtl/if_fifo.sv
// Instruction fetch queue between the fetch stage and decode.
// It buffers (pc, instruction) pairs and hands them to decode in order
// over a valid/ready handshake. It asserts back-pressure toward the PC
// stage through almost_full_o and empties in one cycle on a flush.
// Optional feature: define IF_FIFO_BYPASS_EN to pass an offered entry
// straight to decode in the same cycle when the queue is empty.
module if_fifo #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid_i,
   input  logic [31:0]      if_pc_i,
   input  logic [31:0]      if_inst_i,
   input  logic             flush_i,
   input  logic             id_ready_i,
   output logic             id_valid_o,
   output logic [31:0]      id_pc_o,
   output logic [31:0]      id_inst_o,
   output logic             almost_full_o,
   output logic [PTR_W:0]   count_o,
   output logic             ovf_o
);

   localparam logic [PTR_W:0]   FULL_LVL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   AF_LVL   = (PTR_W+1)'(DEPTH - 1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             ovf;

   logic [31:0]      mem_pc   [DEPTH];
   logic [31:0]      mem_inst [DEPTH];

   logic             empty;
   logic             full;
   logic             bypass;
   logic             head_vld;
   logic             pop;
   logic             push;
   logic             wr_en;
   logic             rd_en;
   logic             drop;

   assign empty = (count == '0);
   assign full  = (count == FULL_LVL);

   // Handshake decode: what moves into and out of storage this cycle.
   always_comb begin
      bypass = 1'b0;
`ifdef IF_FIFO_BYPASS_EN
      // Reset is included so that every output reads 0 while rst is high.
      bypass = empty & if_valid_i & ~flush_i & ~rst;
`endif
      head_vld = ~empty | bypass;
      pop      = head_vld & id_ready_i;
      push     = if_valid_i & ~flush_i & (~full | pop);
      // A bypassed entry that decode takes at once never touches storage.
      wr_en    = push & ~(bypass & id_ready_i);
      rd_en    = pop & ~empty;
      drop     = if_valid_i & ~flush_i & full & ~pop;
   end

   // Head presentation: the bypassed input, the stored head entry, or NOP.
   always_comb begin
      id_valid_o = head_vld;
      id_pc_o    = '0;
      id_inst_o  = '0;
      if (bypass) begin
         id_pc_o   = if_pc_i;
         id_inst_o = if_inst_i;
      end else if (!empty) begin
         id_pc_o   = mem_pc[rd_ptr];
         id_inst_o = mem_inst[rd_ptr];
      end
   end

   assign count_o       = count;
   assign almost_full_o = (count >= AF_LVL);
   assign ovf_o         = ovf;

   // Control state: pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (drop) ovf <= 1'b1;
      end
   end

   // Entry storage: data only, never reset; contents are qualified by count.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_pc[wr_ptr]   <= if_pc_i;
         mem_inst[wr_ptr] <= if_inst_i;
      end
   end

endmodule

// File: tb/tb_if_fifo.sv
// Bench for if_fifo: a queue-based model is checked against the DUT on
// every negative clock edge, and directed literal checks pin the sequence.
module tb_if_fifo;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic             clk;
   logic             rst;
   logic             if_valid_i;
   logic [31:0]      if_pc_i;
   logic [31:0]      if_inst_i;
   logic             flush_i;
   logic             id_ready_i;
   logic             id_valid_o;
   logic [31:0]      id_pc_o;
   logic [31:0]      id_inst_o;
   logic             almost_full_o;
   logic [PTR_W:0]   count_o;
   logic             ovf_o;

   int checks = 0;
   int errors = 0;

   if_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk(clk),
      .rst(rst),
      .if_valid_i(if_valid_i),
      .if_pc_i(if_pc_i),
      .if_inst_i(if_inst_i),
      .flush_i(flush_i),
      .id_ready_i(id_ready_i),
      .id_valid_o(id_valid_o),
      .id_pc_o(id_pc_o),
      .id_inst_o(id_inst_o),
      .almost_full_o(almost_full_o),
      .count_o(count_o),
      .ovf_o(ovf_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: an ordered list of {pc, inst} plus the overflow flag.
   logic [63:0] mq[$];
   bit          m_ovf = 1'b0;

   always @(posedge clk or posedge rst) begin
      bit consume;
      bit do_pop;
      if (rst) begin
         mq.delete();
         m_ovf = 1'b0;
      end else if (flush_i) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         consume = 1'b0;
`ifdef IF_FIFO_BYPASS_EN
         consume = (mq.size() == 0) && if_valid_i && id_ready_i;
`endif
         if (!consume) begin
            do_pop = (mq.size() != 0) && id_ready_i;
            if (do_pop) void'(mq.pop_front());
            if (if_valid_i) begin
               if (mq.size() < DEPTH) mq.push_back({if_pc_i, if_inst_i});
               else m_ovf = 1'b1;
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      logic        e_v;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      e_v    = (mq.size() != 0);
      e_pc   = e_v ? mq[0][63:32] : 32'h0;
      e_inst = e_v ? mq[0][31:0]  : 32'h0;
`ifdef IF_FIFO_BYPASS_EN
      if (mq.size() == 0 && if_valid_i && !flush_i && !rst) begin
         e_v    = 1'b1;
         e_pc   = if_pc_i;
         e_inst = if_inst_i;
      end
`endif
      chk("m_valid", {31'b0, id_valid_o}, {31'b0, e_v});
      chk("m_pc", id_pc_o, e_pc);
      chk("m_inst", id_inst_o, e_inst);
      chk("m_count", {29'b0, count_o}, mq.size());
      chk("m_af", {31'b0, almost_full_o}, (mq.size() >= DEPTH - 1) ? 32'd1 : 32'd0);
      chk("m_ovf", {31'b0, ovf_o}, {31'b0, m_ovf});
   end

   // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic rdy, input logic fl);
      @(posedge clk);
      #2;
      if_valid_i = v;
      if_pc_i    = pc;
      if_inst_i  = inst;
      id_ready_i = rdy;
      flush_i    = fl;
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      if_valid_i = 1'b0;
      if_pc_i    = 32'h0;
      if_inst_i  = 32'h0;
      flush_i    = 1'b0;
      id_ready_i = 1'b0;
      #1;
      chk("rst_valid", {31'b0, id_valid_o}, 32'd0);
      chk("rst_pc", id_pc_o, 32'h0);
      chk("rst_inst", id_inst_o, 32'h0);
      chk("rst_count", {29'b0, count_o}, 32'd0);
      chk("rst_ovf", {31'b0, ovf_o}, 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;

      // Streaming with decode always ready
      drive(1'b1, 32'h0, 32'h24010001, 1'b1, 1'b0);
      chk("s0_count", {29'b0, count_o}, 32'd0);
      drive(1'b1, 32'h4, 32'h24020002, 1'b1, 1'b0);
`ifndef IF_FIFO_BYPASS_EN
      chk("s1_pc", id_pc_o, 32'h0);
      chk("s1_inst", id_inst_o, 32'h24010001);
      chk("s1_count", {29'b0, count_o}, 32'd1);
`endif
      drive(1'b1, 32'h8, 32'h24030003, 1'b1, 1'b0);
`ifndef IF_FIFO_BYPASS_EN
      chk("s2_pc", id_pc_o, 32'h4);
      chk("s2_inst", id_inst_o, 32'h24020002);
`endif
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`ifndef IF_FIFO_BYPASS_EN
      chk("s3_pc", id_pc_o, 32'h8);
      chk("s3_inst", id_inst_o, 32'h24030003);
      chk("s3_count", {29'b0, count_o}, 32'd1);
`endif
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("s4_valid", {31'b0, id_valid_o}, 32'd0);
      chk("s4_pc", id_pc_o, 32'h0);
      chk("s4_inst", id_inst_o, 32'h0);

      // Fill to full with decode stalled; fifth entry overflows
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'(4 * i), 32'h24000000 + 32'(i), 1'b0, 1'b0);
         chk("fill_count", {29'b0, count_o}, 32'(i));
         chk("fill_af", {31'b0, almost_full_o}, (i >= 3) ? 32'd1 : 32'd0);
         chk("fill_ovf", {31'b0, ovf_o}, 32'd0);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("full_count", {29'b0, count_o}, 32'd4);
      chk("full_ovf", {31'b0, ovf_o}, 32'd1);
      chk("full_af", {31'b0, almost_full_o}, 32'd1);
      chk("full_head", id_pc_o, 32'h0);

      // Full with simultaneous pop and push
      drive(1'b1, 32'h20, 32'h24000020, 1'b1, 1'b0);
      chk("fp_head0", id_pc_o, 32'h0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("fp_count", {29'b0, count_o}, 32'd4);
      chk("fp_ovf", {31'b0, ovf_o}, 32'd1);
      chk("fp_head1", id_pc_o, 32'h4);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("fp_head2", id_pc_o, 32'h8);
      chk("fp_count3", {29'b0, count_o}, 32'd3);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("fp_head3", id_pc_o, 32'hC);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("fp_head4", id_pc_o, 32'h20);
      chk("fp_inst4", id_inst_o, 32'h24000020);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("fp_empty", {31'b0, id_valid_o}, 32'd0);

      // Pointer wrap: ten push/pop pairs
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'(4 * i), 32'h24100000 + 32'(i), 1'b1, 1'b0);
`ifndef IF_FIFO_BYPASS_EN
         if (i > 0) chk("wrap_pc", id_pc_o, 32'(4 * (i - 1)));
`endif
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`ifndef IF_FIFO_BYPASS_EN
      chk("wrap_last", id_pc_o, 32'h24);
`endif
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("wrap_empty", {29'b0, count_o}, 32'd0);

      // Flush with three queued entries and an offered one
      drive(1'b1, 32'h30, 32'h24000030, 1'b0, 1'b0);
      drive(1'b1, 32'h34, 32'h24000034, 1'b0, 1'b0);
      drive(1'b1, 32'h38, 32'h24000038, 1'b0, 1'b0);
      drive(1'b1, 32'h40, 32'h24000040, 1'b0, 1'b1);
      chk("fl_pre_count", {29'b0, count_o}, 32'd3);
      chk("fl_pre_ovf", {31'b0, ovf_o}, 32'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("fl_count", {29'b0, count_o}, 32'd0);
      chk("fl_valid", {31'b0, id_valid_o}, 32'd0);
      chk("fl_ovf", {31'b0, ovf_o}, 32'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of operation
      drive(1'b1, 32'h50, 32'h24000050, 1'b0, 1'b0);
      drive(1'b1, 32'h54, 32'h24000054, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("ar_pre_count", {29'b0, count_o}, 32'd2);
      rst = 1'b1;
      #1;
      chk("ar_count", {29'b0, count_o}, 32'd0);
      chk("ar_valid", {31'b0, id_valid_o}, 32'd0);
      chk("ar_pc", id_pc_o, 32'h0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      drive(1'b1, 32'h58, 32'h24000058, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("ar2_pc", id_pc_o, 32'h58);
      chk("ar2_count", {29'b0, count_o}, 32'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("ar2_empty", {29'b0, count_o}, 32'd0);

`ifdef IF_FIFO_BYPASS_EN
      // Zero-latency pass-through on an empty queue
      drive(1'b1, 32'h44, 32'h24000044, 1'b1, 1'b0);
      chk("bp_valid", {31'b0, id_valid_o}, 32'd1);
      chk("bp_pc", id_pc_o, 32'h44);
      chk("bp_count", {29'b0, count_o}, 32'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("bp_after", {29'b0, count_o}, 32'd0);
`endif

      @(posedge clk);
      #2;
      @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_fifo.md
Name: if_fifo

Overview:
- Instruction fetch queue between the PC/instruction-memory fetch stage and the decode stage of the 5-stage MIPS pipeline.
- Buffers (pc, instruction) pairs returned from instruction memory and presents them in order to decode with a valid/ready handshake.
- Generates back-pressure toward the PC stage and supports a single-cycle flush on branch/exception redirect.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  pipeline clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_valid_i  input  1  a fetched instruction is offered this cycle.
- if_pc_i  input  32  address of the offered instruction.
- if_inst_i  input  32  offered instruction word.
- flush_i  input  1  discard all queued and offered entries.
- id_ready_i  input  1  decode accepts the head entry this cycle.
- id_valid_o  output  1  head entry valid.
- id_pc_o  output  32  head entry pc; 0 when id_valid_o=0.
- id_inst_o  output  32  head entry instruction; 0 (NOP) when id_valid_o=0.
- almost_full_o  output  1  count >= DEPTH-1; the PC stage holds pc / deasserts ce.
- count_o  output  PTR_W+1  current number of entries.
- ovf_o  output  1  sticky overflow flag.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, ovf_o=0. All outputs read 0 immediately, without waiting for a clock edge. Storage contents are don't-care.
- pop = id_valid_o & id_ready_i.
- push = if_valid_i & ~flush_i & ((count<DEPTH) | pop).
- Push: write {if_pc_i, if_inst_i} at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap at PTR_W bits).
- Pop: rd_ptr increments modulo DEPTH.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: an entry pushed in cycle N appears at the head in cycle N+1. Head outputs are driven combinationally from registered storage and rd_ptr.
- id_valid_o = (count != 0).
- Head outputs are forced to 0 when id_valid_o=0.
- almost_full_o and count_o are decoded from the count register only; there is no combinational path from the inputs.
- Full + simultaneous pop: push is accepted and count stays at DEPTH.
- Full, no pop, if_valid_i=1: the offered entry is dropped, ovf_o is set to 1, and queue contents are unchanged.
- ovf_o clears only on rst or flush_i.
- Empty + id_ready_i: no pop; pointers are unchanged.
- flush_i=1, next edge: count=0, wr_ptr=rd_ptr=0, ovf_o=0. The offered input and any pop in the same cycle are ignored. id_valid_o=0 from the following cycle.
- Reset asserted mid-operation: the queue empties asynchronously. The first push after rst deasserts lands in slot 0.
- No internal state machine beyond the pointer/count datapath; the queue states are EMPTY (count=0), PARTIAL, and FULL (count=DEPTH), all derived from count.

Optional Feature:
- Macro: IF_FIFO_BYPASS_EN.
- With the macro defined: when count=0, if_valid_i=1, flush_i=0, and id_ready_i=1, the input passes combinationally to the id_* outputs with id_valid_o=1 in the same cycle (zero latency), and is not written into storage.
  - When count=0 and if_valid_i=1, id_valid_o=1 and the id_* outputs show the input regardless of id_ready_i.
  - If id_ready_i=0 in that cycle, the entry is also pushed as normal.
- Without the macro: fixed 1-cycle latency as above; id_* outputs depend only on registers.

Test Plan:
- Reset: assert rst with no clock edge -> id_valid_o=0, id_pc_o=0, id_inst_o=0, count_o=0, ovf_o=0 immediately.
- Streaming: push pc 0x0/0x4/0x8 with instructions 0x24010001/0x24020002/0x24030003 on consecutive cycles, id_ready_i=1 -> head shows pc 0x0 one cycle after its push, then 0x4 and 0x8 on the following cycles, in order; count_o never exceeds 1.
- Fill and overflow: id_ready_i=0, push 5 entries (pc 0x0..0x10) -> almost_full_o=1 after 3rd push; count_o=4 after 4th push; 5th (pc 0x10) dropped, ovf_o=1. Drain -> pcs 0x0, 0x4, 0x8, 0xC in order.
- Full with simultaneous pop and push: at count=4, if_valid_i=1 with pc 0x20, id_ready_i=1 -> count_o stays 4, ovf_o unchanged; 0x20 emerges after the remaining 3 entries.
- Pointer wrap: 10 push/pop pairs with DEPTH=4 -> output pc sequence 0x0..0x24 intact across wrap.
- Flush: count=3, flush_i=1 with if_valid_i=1 (pc 0x40) -> next cycle count_o=0, id_valid_o=0, ovf_o=0, and 0x40 never appears. With IF_FIFO_BYPASS_EN, an empty queue with id_ready_i=1 shows pc 0x44 on the id_* outputs in the same cycle it is offered.
